// File: rtl/arb_rr4_enc_if.sv
// Request/grant bundle between the requesting blocks and arb_rr4_enc.
// The master side (requesters) drives en/req/done; the slave side (arbiter)
// returns the registered grant, its encoded index, valid and timeout pulse.
interface arb_rr4_enc_if;
   logic       en;
   logic [3:0] req;
   logic       done;
   logic [3:0] gnt;
   logic [1:0] gnt_id;
   logic       gnt_valid;
   logic       timeout;

   modport master (
      output en, req, done,
      input  gnt, gnt_id, gnt_valid, timeout
   );

   modport slave (
      input  en, req, done,
      output gnt, gnt_id, gnt_valid, timeout
   );
endinterface

// File: rtl/arb_rr4_enc.sv
// arb_rr4_enc: four-requester round-robin arbiter with held grants.
// IDLE -> GRANT on a sampled request; the owner keeps the resource until it
// releases (done, dropped request or en low), then one mandatory GAP cycle.
// gnt, gnt_id, gnt_valid and timeout are all registered.
// Optional feature macro: ARB_TIMEOUT_EN -- forces a release after the owner
// has held the grant for HOLD_MAX+1 cycles and pulses timeout for one cycle.
module arb_rr4_enc #(
   parameter int HOLD_MAX = 15,
   parameter int CNT_W    = 4
) (
   input  logic         clk,
   input  logic         rst_n,
   arb_rr4_enc_if.slave bus
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_GRANT = 2'd1,
      ST_GAP   = 2'd2
   } state_t;

   state_t     state_r, state_s;
   logic [1:0] ptr_r, ptr_s;
   logic [3:0] gnt_r, gnt_s;
   logic [1:0] gnt_id_r, gnt_id_s;
   logic       gnt_valid_r, gnt_valid_s;
   logic       timeout_r, timeout_s;
   logic [1:0] cand_s;
   logic [1:0] win_id_s;
   logic       win_found_s;
   logic       release_s;
   logic       force_s;

   // The hold counter must be able to represent HOLD_MAX.
   if ((2 ** CNT_W) <= HOLD_MAX) begin : g_cnt_w_too_small
      $error("arb_rr4_enc: 2**CNT_W must exceed HOLD_MAX");
   end

   // Encoded index to one-hot grant vector.
   function automatic logic [3:0] onehot4(input logic [1:0] id);
      logic [3:0] oh;
      case (id)
         2'd0:    oh = 4'b0001;
         2'd1:    oh = 4'b0010;
         2'd2:    oh = 4'b0100;
         2'd3:    oh = 4'b1000;
         default: oh = 4'b0000;
      endcase
      return oh;
   endfunction

   // Owner gives the resource back when it says done, drops its request or the arbiter is disabled.
   assign release_s = bus.done | ~bus.req[gnt_id_r] | ~bus.en;

`ifdef ARB_TIMEOUT_EN
   logic [CNT_W-1:0] cnt_r;

   assign force_s = (cnt_r == CNT_W'(HOLD_MAX));

   // Hold counter: counts held cycles in GRANT, cleared everywhere else so a new grant starts at 0.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_r <= {CNT_W{1'b0}};
      end else if ((state_r == ST_GRANT) && !release_s && !force_s) begin
         if (cnt_r != {CNT_W{1'b1}}) begin
            cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
         end else begin
            cnt_r <= cnt_r;
         end
      end else begin
         cnt_r <= {CNT_W{1'b0}};
      end
   end
`else
   assign force_s = 1'b0;
`endif

   // Round-robin search: ptr+1, ptr+2, ptr+3, ptr (mod 4); first set request wins.
   always_comb begin
      cand_s      = 2'd0;
      win_id_s    = 2'd0;
      win_found_s = 1'b0;
      for (int i = 1; i < 5; i++) begin
         cand_s = ptr_r + 2'(i);
         if (!win_found_s && bus.req[cand_s]) begin
            win_found_s = 1'b1;
            win_id_s    = cand_s;
         end else begin
            win_found_s = win_found_s;
         end
      end
   end

   // Next state and next registered outputs; outputs default to "no grant".
   always_comb begin
      state_s     = state_r;
      ptr_s       = ptr_r;
      gnt_s       = 4'b0000;
      gnt_id_s    = 2'd0;
      gnt_valid_s = 1'b0;
      timeout_s   = 1'b0;
      case (state_r)
         ST_IDLE, ST_GAP: begin
            if (bus.en && win_found_s) begin
               state_s     = ST_GRANT;
               ptr_s       = win_id_s;
               gnt_s       = onehot4(win_id_s);
               gnt_id_s    = win_id_s;
               gnt_valid_s = 1'b1;
            end else begin
               state_s = ST_IDLE;
            end
         end
         ST_GRANT: begin
            if (release_s) begin
               state_s = ST_GAP;
            end else if (force_s) begin
               state_s   = ST_GAP;
               timeout_s = 1'b1;
            end else begin
               state_s     = ST_GRANT;
               gnt_s       = gnt_r;
               gnt_id_s    = gnt_id_r;
               gnt_valid_s = 1'b1;
            end
         end
         default: begin
            state_s = ST_IDLE;
         end
      endcase
   end

   // State, last-winner pointer and output registers; ptr resets to 3 so requester 0 goes first.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r     <= ST_IDLE;
         ptr_r       <= 2'd3;
         gnt_r       <= 4'b0000;
         gnt_id_r    <= 2'd0;
         gnt_valid_r <= 1'b0;
         timeout_r   <= 1'b0;
      end else begin
         state_r     <= state_s;
         ptr_r       <= ptr_s;
         gnt_r       <= gnt_s;
         gnt_id_r    <= gnt_id_s;
         gnt_valid_r <= gnt_valid_s;
         timeout_r   <= timeout_s;
      end
   end

   assign bus.gnt       = gnt_r;
   assign bus.gnt_id    = gnt_id_r;
   assign bus.gnt_valid = gnt_valid_r;
   assign bus.timeout   = timeout_r;

endmodule

// File: tb/tb_arb_rr4_enc.sv
// Directed testbench for arb_rr4_enc: round robin, held grants, GAP cycle,
// enable parking, asynchronous reset and (with ARB_TIMEOUT_EN) forced release.
module tb_arb_rr4_enc;
   logic clk;
   logic rst_n;
   int   n_checks;
   int   n_fail;

   arb_rr4_enc_if bus ();

   arb_rr4_enc #(.HOLD_MAX(15), .CNT_W(4)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance one rising edge and settle 1 time unit past it.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [3:0] eg, input logic [1:0] ei,
                      input logic ev, input logic et);
      n_checks++;
      assert ({bus.gnt, bus.gnt_id, bus.gnt_valid, bus.timeout} === {eg, ei, ev, et}) else begin
         n_fail++;
         $error("FAIL %s: got gnt=%b id=%0d valid=%b timeout=%b, want gnt=%b id=%0d valid=%b timeout=%b",
                tag, bus.gnt, bus.gnt_id, bus.gnt_valid, bus.timeout, eg, ei, ev, et);
      end
   endtask

   task automatic chk_none(input string tag);
      chk(tag, 4'b0000, 2'd0, 1'b0, 1'b0);
   endtask

   task automatic chk_gnt(input string tag, input logic [1:0] id);
      logic [3:0] one;
      one = 4'b0001;
      chk(tag, one << id, id, 1'b1, 1'b0);
   endtask

   initial begin
      logic [1:0] seq [4];
      seq[0] = 2'd1; seq[1] = 2'd2; seq[2] = 2'd3; seq[3] = 2'd0;
      n_checks = 0;
      n_fail   = 0;
      rst_n    = 1'b0;
      bus.en   = 1'b0;
      bus.req  = 4'b0000;
      bus.done = 1'b0;
      #12;
      chk_none("reset");
      @(negedge clk);
      rst_n = 1'b1;

      // 1: all requesting, done pulsed every grant -> 0,1,2,3,0 with one dead cycle between
      bus.en  = 1'b1;
      bus.req = 4'b1111;
      tick();
      chk_gnt("rr_first", 2'd0);
      for (int k = 0; k < 4; k++) begin
         bus.done = 1'b1;
         tick();
         chk_none($sformatf("rr_gap%0d", k));
         bus.done = 1'b0;
         tick();
         chk_gnt($sformatf("rr_grant%0d", k), seq[k]);
      end
      bus.done = 1'b1;
      tick();
      chk_none("rr_last_gap");
      bus.done = 1'b0;
      bus.req  = 4'b0000;
      tick();
      chk_none("rr_idle");

      // 2: single requester 2, then drop request
      bus.req = 4'b0100;
      tick();
      chk_gnt("single_grant", 2'd2);
      tick();
      chk_gnt("single_hold", 2'd2);
      bus.req = 4'b0000;
      tick();
      chk_none("single_drop_gap");
      tick();
      chk_none("single_idle");

      // 3: owner 1 not preempted, next winner is 3 (after 1), not 0
      bus.req = 4'b0010;
      tick();
      chk_gnt("own1_grant", 2'd1);
      bus.req = 4'b1011;
      tick();
      chk_gnt("own1_hold_a", 2'd1);
      tick();
      chk_gnt("own1_hold_b", 2'd1);
      bus.done = 1'b1;
      tick();
      chk_none("own1_release");
      bus.done = 1'b0;
      tick();
      chk_gnt("after1_is3", 2'd3);

      // 4: en low while 3 owns -> release, no grants while parked, then 0 wins
      bus.en  = 1'b0;
      bus.req = 4'b1111;
      tick();
      chk_none("en0_release");
      tick();
      chk_none("en0_parked_a");
      tick();
      chk_none("en0_parked_b");
      bus.en = 1'b1;
      tick();
      chk_gnt("reenable_id0", 2'd0);

      // 5: async reset mid-grant clears outputs before the next edge; ptr back to 3
      bus.done = 1'b1;
      tick();
      bus.done = 1'b0;
      tick();
      chk_gnt("pre_reset_id1", 2'd1);
      #2;
      rst_n = 1'b0;
      #1;
      chk_none("async_reset");
      tick();
      chk_none("reset_held");
      rst_n = 1'b1;
      tick();
      chk_gnt("post_reset_id0", 2'd0);

      // 6: requesters 0 and 1 held, no done
      rst_n = 1'b0;
      tick();
      rst_n   = 1'b1;
      bus.req = 4'b0011;
      tick();
      chk_gnt("hold_start", 2'd0);
      for (int k = 0; k < 15; k++) begin
         tick();
         chk_gnt($sformatf("hold_c%0d", k + 2), 2'd0);
      end
      tick();
`ifdef ARB_TIMEOUT_EN
      chk("timeout_pulse", 4'b0000, 2'd0, 1'b0, 1'b1);
      tick();
      chk_gnt("after_timeout_id1", 2'd1);
`else
      chk_gnt("hold_c17", 2'd0);
      tick();
      chk_gnt("hold_c18", 2'd0);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end
endmodule
